// File: rtl/branch_unit_if.sv
// Bus bundle for branch_unit: request fields from the decoder and the
// result fields returned by the branch unit.
interface branch_unit_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic [7:0]        opcode;
   logic [7:0]        flags;
   logic [ADDR_W-1:0] pc_in;
   logic [7:0]        offset;
   logic              busy;
   logic              done;
   logic              taken;
   logic              illegal;
   logic [ADDR_W-1:0] pc_out;
   logic [1:0]        cycles;

   // Decoder side: issues requests, observes results.
   modport master (
      output start, opcode, flags, pc_in, offset,
      input  busy, done, taken, illegal, pc_out, cycles
   );

   // Branch unit side.
   modport slave (
      input  start, opcode, flags, pc_in, offset,
      output busy, done, taken, illegal, pc_out, cycles
   );
endinterface

// File: rtl/branch_unit.sv
// Multi-cycle 6502 relative-branch unit with 6502 cycle accounting.
// A taken branch costs one extra state (ADD_LO); a page cross costs a
// further state (FIX_HI) that corrects the upper address bits.
// Optional feature macro: BRANCH_BRA_EN (65C02 BRA, opcode 8'h80, always taken).
// ADDR_W must be at least 9; the page is always the low 8 bits.
module branch_unit #(
   parameter int ADDR_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   branch_unit_if.slave bus
);

   localparam int HI_W = ADDR_W - 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EVAL,
      S_ADD_LO,
      S_FIX_HI
   } state_t;

   state_t state, state_nx;

   // Request captured at the accept edge; inputs may change afterwards.
   logic [7:0]        op_q;
   logic [3:0]        flg_q;   // {N, V, Z, C}
   logic [ADDR_W-1:0] pc_q;
   logic [7:0]        off_q;
   logic [7:0]        lo_q;    // low byte of the target, kept for FIX_HI

   // Decode / datapath terms
   logic              accept;
   logic              is_bra;
   logic              legal;
   logic              sel_flag;
   logic              cond_taken;
   logic [8:0]        lo_sum;
   logic              page_cross;
   logic [HI_W-1:0]   hi_adj;

   // Result staged for the done pulse
   logic              fin;
   logic              res_taken;
   logic              res_illegal;
   logic [1:0]        res_cycles;
   logic [ADDR_W-1:0] res_pc;

   assign accept = (state == S_IDLE) && bus.start;

`ifdef BRANCH_BRA_EN
   assign is_bra = (op_q == 8'h80);
`else
   assign is_bra = 1'b0;
`endif

   assign legal = (op_q[4:0] == 5'b10000) || is_bra;

   // Select the flag named by opcode[7:6].
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel_flag = 1'b0;
      case (op_q[7:6])
         2'b00:   sel_flag = flg_q[3];   // N
         2'b01:   sel_flag = flg_q[2];   // V
         2'b10:   sel_flag = flg_q[0];   // C
         default: sel_flag = flg_q[1];   // Z
      endcase
   end

   assign cond_taken = legal && (is_bra || (sel_flag == op_q[5]));

   // Low-byte add; a carry out against a positive offset, or no carry
   // against a negative one, means the target lies on another page.
   assign lo_sum     = {1'b0, pc_q[7:0]} + {1'b0, off_q};
   assign page_cross = off_q[7] ^ lo_sum[8];
   assign hi_adj     = off_q[7] ? (pc_q[ADDR_W-1:8] - HI_W'(1))
                                : (pc_q[ADDR_W-1:8] + HI_W'(1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (bus.start) state_nx = S_EVAL;
         S_EVAL:   state_nx = cond_taken ? S_ADD_LO : S_IDLE;
         S_ADD_LO: state_nx = page_cross ? S_FIX_HI : S_IDLE;
         S_FIX_HI: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Output decode: which state finishes and what result it reports.
   always_comb begin
      fin         = 1'b0;
      res_taken   = 1'b0;
      res_illegal = 1'b0;
      res_cycles  = 2'd0;
      res_pc      = pc_q;
      case (state)
         S_EVAL: begin
            if (!cond_taken) begin
               fin         = 1'b1;
               res_illegal = !legal;
            end
         end
         S_ADD_LO: begin
            if (!page_cross) begin
               fin        = 1'b1;
               res_taken  = 1'b1;
               res_cycles = 2'd1;
               res_pc     = {pc_q[ADDR_W-1:8], lo_sum[7:0]};
            end
         end
         S_FIX_HI: begin
            fin        = 1'b1;
            res_taken  = 1'b1;
            res_cycles = 2'd2;
            res_pc     = {hi_adj, lo_q};
         end
         default: ;
      endcase
   end

   assign bus.busy = (state != S_IDLE);

   // Capture the request on accept and keep the low target byte for FIX_HI.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q  <= '0;
         flg_q <= '0;
         pc_q  <= '0;
         off_q <= '0;
         lo_q  <= '0;
      end else begin
         if (accept) begin
            op_q  <= bus.opcode;
            flg_q <= {bus.flags[7], bus.flags[6], bus.flags[1], bus.flags[0]};
            pc_q  <= bus.pc_in;
            off_q <= bus.offset;
         end
         if (state == S_ADD_LO) begin
            lo_q <= lo_sum[7:0];
         end
      end
   end

   // Result registers: load together with the done pulse, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.done    <= 1'b0;
         bus.taken   <= 1'b0;
         bus.illegal <= 1'b0;
         bus.cycles  <= 2'd0;
         bus.pc_out  <= '0;
      end else begin
         bus.done <= fin;
         if (fin) begin
            bus.taken   <= res_taken;
            bus.illegal <= res_illegal;
            bus.cycles  <= res_cycles;
            bus.pc_out  <= res_pc;
         end
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed cases followed by random
// branches, compared against a behavioural model built from whole-address
// arithmetic (target = pc + sign-extended offset, page cross = upper bits differ).
module tb_branch_unit;

   localparam int ADDR_W = 16;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [ADDR_W-1:0] prev_pc;

   branch_unit_if #(.ADDR_W(ADDR_W)) ifc ();

   branch_unit #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model from the architectural branch rules.
   task automatic model(input logic [7:0] op, input logic [7:0] fl,
                        input logic [ADDR_W-1:0] pc, input logic [7:0] off,
                        output logic ill, output logic tk,
                        output logic [ADDR_W-1:0] npc, output logic [1:0] cyc);
      logic legal, bra, f;
      logic [ADDR_W-1:0] target;
      legal = (op[4:0] == 5'b10000);
      bra   = 1'b0;
`ifdef BRANCH_BRA_EN
      if (op == 8'h80) begin
         legal = 1'b1;
         bra   = 1'b1;
      end
`endif
      case (op[7:6])
         2'd0:    f = fl[7];
         2'd1:    f = fl[6];
         2'd2:    f = fl[0];
         default: f = fl[1];
      endcase
      tk     = legal && (bra || (f == op[5]));
      ill    = !legal;
      target = pc + {{(ADDR_W-8){off[7]}}, off};
      npc    = tk ? target : pc;
      if (!tk)                                   cyc = 2'd0;
      else if (target[ADDR_W-1:8] == pc[ADDR_W-1:8]) cyc = 2'd1;
      else                                       cyc = 2'd2;
   endtask

   // Issue one request (called just after a rising edge with the unit idle
   // or in its done cycle) and check the complete result.
   task automatic run_op(input logic [7:0] op, input logic [7:0] fl,
                         input logic [ADDR_W-1:0] pc, input logic [7:0] off,
                         input bit poke);
      logic ill, tk;
      logic [ADDR_W-1:0] npc;
      logic [1:0] cyc;
      int n;
      model(op, fl, pc, off, ill, tk, npc, cyc);
      ifc.start  = 1'b1;
      ifc.opcode = op;
      ifc.flags  = fl;
      ifc.pc_in  = pc;
      ifc.offset = off;
      @(posedge clk); #1;
      ifc.start  = 1'b0;
      ifc.opcode = 8'($urandom);
      ifc.flags  = 8'($urandom);
      ifc.pc_in  = ADDR_W'($urandom);
      ifc.offset = 8'($urandom);
      check("busy_after_accept", 32'(ifc.busy), 32'd1);
      check("done_low_after_accept", 32'(ifc.done), 32'd0);
      if (poke) ifc.start = 1'b1;
      n = 0;
      while (1) begin
         @(posedge clk); #1;
         ifc.start = 1'b0;
         n++;
         if (ifc.done === 1'b1 || n >= 6) break;
         check("pc_out_hold", 32'(ifc.pc_out), 32'(prev_pc));
      end
      check("done_seen", 32'(ifc.done), 32'd1);
      check("latency", 32'(n), 32'(1 + cyc));
      check("busy_low_at_done", 32'(ifc.busy), 32'd0);
      check("taken", 32'(ifc.taken), 32'(tk));
      check("illegal", 32'(ifc.illegal), 32'(ill));
      check("cycles", 32'(ifc.cycles), 32'(cyc));
      check("pc_out", 32'(ifc.pc_out), 32'(npc));
      prev_pc = npc;
   endtask

   initial begin
      logic [2:0] hi3;
      logic [7:0] op;
      checks     = 0;
      errors     = 0;
      prev_pc    = '0;
      rst        = 1'b1;
      ifc.start  = 1'b0;
      ifc.opcode = 8'h00;
      ifc.flags  = 8'h00;
      ifc.pc_in  = '0;
      ifc.offset = 8'h00;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_done", 32'(ifc.done), 32'd0);
      check("rst_taken", 32'(ifc.taken), 32'd0);
      check("rst_illegal", 32'(ifc.illegal), 32'd0);
      check("rst_cycles", 32'(ifc.cycles), 32'd0);
      check("rst_pc_out", 32'(ifc.pc_out), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases, issued back to back
      run_op(8'hF0, 8'h02, 16'h1234, 8'h05, 1'b0);   // BEQ taken
      check("beq_target", 32'(ifc.pc_out), 32'h1239);
      run_op(8'hD0, 8'h02, 16'h1234, 8'h05, 1'b0);   // BNE not taken
      check("bne_target", 32'(ifc.pc_out), 32'h1234);
      run_op(8'h90, 8'h00, 16'h12FE, 8'h10, 1'b0);   // BCC forward cross
      check("bcc_fwd_target", 32'(ifc.pc_out), 32'h130E);
      run_op(8'h90, 8'h00, 16'h1205, 8'hF0, 1'b0);   // BCC backward cross
      check("bcc_back_target", 32'(ifc.pc_out), 32'h11F5);
      run_op(8'h90, 8'h00, 16'hFFF0, 8'h20, 1'b0);   // wrap to page 0
      check("bcc_wrap_target", 32'(ifc.pc_out), 32'h0010);
      run_op(8'h10, 8'h00, 16'h0000, 8'h80, 1'b0);   // BPL wrap to top page
      check("bpl_wrap_target", 32'(ifc.pc_out), 32'hFF80);
      run_op(8'hEA, 8'hFF, 16'h4321, 8'h11, 1'b0);   // NOP: illegal
      run_op(8'h80, 8'h00, 16'h12FE, 8'h10, 1'b0);   // BRA (config dependent)
      run_op(8'hB0, 8'h01, 16'h20F0, 8'h20, 1'b1);   // BCS, stray start while busy

      // A stray start must not have launched a second operation
      @(posedge clk); #1;
      check("no_extra_op_busy", 32'(ifc.busy), 32'd0);
      check("no_extra_op_done", 32'(ifc.done), 32'd0);

      // Reset in ADD_LO aborts with no done pulse
      ifc.start  = 1'b1;
      ifc.opcode = 8'hF0;
      ifc.flags  = 8'h02;
      ifc.pc_in  = 16'h12FE;
      ifc.offset = 8'h10;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(ifc.busy), 32'd0);
      check("abort_done", 32'(ifc.done), 32'd0);
      check("abort_taken", 32'(ifc.taken), 32'd0);
      check("abort_cycles", 32'(ifc.cycles), 32'd0);
      check("abort_pc_out", 32'(ifc.pc_out), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_no_done", 32'(ifc.done), 32'd0);
      end
      rst     = 1'b0;
      prev_pc = '0;
      @(posedge clk); #1;
      run_op(8'h30, 8'h80, 16'h0456, 8'hFA, 1'b0);   // BMI after abort

      // Random branches, mostly legal opcodes
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            op = 8'($urandom);
         end else begin
            hi3 = 3'($urandom_range(0, 7));
            op  = {hi3, 5'b10000};
         end
         run_op(op, 8'($urandom), ADDR_W'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
